// File: rtl/lockstep_cmp.sv
// lockstep_cmp: compares reference and UUT read data per channel after a fixed read latency,
// latching the first mismatch and keeping saturating compare/mismatch statistics.
module lockstep_cmp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_CH     = 2,
  parameter int LATENCY    = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_arm,
  input  logic                         i_clear,
  input  logic [NUM_CH-1:0]            i_en,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data_ref,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data_uut,
  output logic [1:0]                   o_state,
  output logic                         o_equal,
  output logic                         o_fault,
  output logic [CNT_WIDTH-1:0]         o_cmp_cnt,
  output logic [CNT_WIDTH-1:0]         o_mis_cnt,
  output logic [2:0]                   o_fault_ch,
  output logic [ADDR_WIDTH-1:0]        o_fault_addr,
  output logic [DATA_WIDTH-1:0]        o_fault_ref,
  output logic [DATA_WIDTH-1:0]        o_fault_uut
);
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, FAULT = 2'b10} state_t;
  state_t                       state_q, state_d;
  logic                         equal_q, equal_d;
  logic                         fault_q, fault_d;
  logic [CNT_WIDTH-1:0]         cmp_cnt_q, cmp_cnt_d;
  logic [CNT_WIDTH-1:0]         mis_cnt_q, mis_cnt_d;
  logic [2:0]                   fault_ch_q, fault_ch_d;
  logic [ADDR_WIDTH-1:0]        fault_addr_q, fault_addr_d;
  logic [DATA_WIDTH-1:0]        fault_ref_q, fault_ref_d;
  logic [DATA_WIDTH-1:0]        fault_uut_q, fault_uut_d;
  logic [NUM_CH-1:0]            en_dly;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr_dly;
  logic [NUM_CH-1:0]            qual, mis;
  logic                         any_qual, any_mis, cap;
  logic [2:0]                   hit_ch;
  logic [ADDR_WIDTH-1:0]        hit_addr;
  logic [DATA_WIDTH-1:0]        hit_ref, hit_uut;
  if (LATENCY == 0) begin : g_nodly
    assign en_dly   = i_en;
    assign addr_dly = i_addr;
  end else begin : g_dly
    logic [NUM_CH-1:0]            en_pipe_q [LATENCY];
    logic [NUM_CH-1:0]            en_pipe_d [LATENCY];
    logic [NUM_CH*ADDR_WIDTH-1:0] addr_pipe_q [LATENCY];
    logic [NUM_CH*ADDR_WIDTH-1:0] addr_pipe_d [LATENCY];
    always_comb begin
      en_pipe_d[0]   = i_clear ? '0 : i_en;
      addr_pipe_d[0] = i_clear ? '0 : i_addr;
      for (int s = 1; s < LATENCY; s++) begin
        en_pipe_d[s]   = i_clear ? '0 : en_pipe_q[s-1];
        addr_pipe_d[s] = i_clear ? '0 : addr_pipe_q[s-1];
      end
    end
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        en_pipe_q   <= '{default: '0};
        addr_pipe_q <= '{default: '0};
      end else begin
        en_pipe_q   <= en_pipe_d;
        addr_pipe_q <= addr_pipe_d;
      end
    end
    assign en_dly   = en_pipe_q[LATENCY-1];
    assign addr_dly = addr_pipe_q[LATENCY-1];
  end
  // Descending scan so the lowest-index mismatching channel wins the capture.
  always_comb begin
    qual     = en_dly & {NUM_CH{state_q == ARMED || state_q == FAULT}};
    mis      = '0;
    hit_ch   = '0;
    hit_addr = '0;
    hit_ref  = '0;
    hit_uut  = '0;
    for (int k = 0; k < NUM_CH; k++)
      mis[k] = qual[k] && (i_data_ref[k*DATA_WIDTH +: DATA_WIDTH] != i_data_uut[k*DATA_WIDTH +: DATA_WIDTH]);
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (mis[k]) begin
        hit_ch   = 3'(k);
        hit_addr = addr_dly[k*ADDR_WIDTH +: ADDR_WIDTH];
        hit_ref  = i_data_ref[k*DATA_WIDTH +: DATA_WIDTH];
        hit_uut  = i_data_uut[k*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  always_comb begin
    any_qual     = |qual;
    any_mis      = |mis;
    cap          = !i_clear && state_q == ARMED && any_mis;
    state_d      = i_clear ? IDLE :
                   state_q == IDLE  ? (i_arm ? ARMED : IDLE) :
                   state_q == ARMED ? (any_mis ? FAULT : ARMED) :
                   state_q == FAULT ? FAULT : IDLE;
    fault_d      = state_d == FAULT;
    equal_d      = i_clear || !any_mis;
    cmp_cnt_d    = i_clear ? '0 : cmp_cnt_q + CNT_WIDTH'(any_qual && !(&cmp_cnt_q));
    mis_cnt_d    = i_clear ? '0 : mis_cnt_q + CNT_WIDTH'(any_mis && !(&mis_cnt_q));
    fault_ch_d   = i_clear ? '0 : cap ? hit_ch   : fault_ch_q;
    fault_addr_d = i_clear ? '0 : cap ? hit_addr : fault_addr_q;
    fault_ref_d  = i_clear ? '0 : cap ? hit_ref  : fault_ref_q;
    fault_uut_d  = i_clear ? '0 : cap ? hit_uut  : fault_uut_q;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      equal_q      <= 1'b1;
      fault_q      <= 1'b0;
      cmp_cnt_q    <= '0;
      mis_cnt_q    <= '0;
      fault_ch_q   <= '0;
      fault_addr_q <= '0;
      fault_ref_q  <= '0;
      fault_uut_q  <= '0;
    end else begin
      state_q      <= state_d;
      equal_q      <= equal_d;
      fault_q      <= fault_d;
      cmp_cnt_q    <= cmp_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
      fault_ch_q   <= fault_ch_d;
      fault_addr_q <= fault_addr_d;
      fault_ref_q  <= fault_ref_d;
      fault_uut_q  <= fault_uut_d;
    end
  end
  assign o_state      = state_q;
  assign o_equal      = equal_q;
  assign o_fault      = fault_q;
  assign o_cmp_cnt    = cmp_cnt_q;
  assign o_mis_cnt    = mis_cnt_q;
  assign o_fault_ch   = fault_ch_q;
  assign o_fault_addr = fault_addr_q;
  assign o_fault_ref  = fault_ref_q;
  assign o_fault_uut  = fault_uut_q;
endmodule

// File: tb/tb_lockstep_cmp.sv
// tb_lockstep_cmp: scoreboard bench; a request-history reference model predicts every cycle's outputs.
module tb_lockstep_cmp;
  localparam int DW = 32, AW = 10, NC = 2, LAT = 1, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, arm, clr;
  logic [NC-1:0] en;
  logic [NC*AW-1:0] addr;
  logic [NC*DW-1:0] dref, duut;
  logic [1:0] o_state;
  logic o_equal, o_fault;
  logic [CW-1:0] o_cmp_cnt, o_mis_cnt;
  logic [2:0] o_fault_ch;
  logic [AW-1:0] o_fault_addr;
  logic [DW-1:0] o_fault_ref, o_fault_uut;
  lockstep_cmp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .LATENCY(LAT), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_arm(arm), .i_clear(clr), .i_en(en), .i_addr(addr),
    .i_data_ref(dref), .i_data_uut(duut), .o_state(o_state), .o_equal(o_equal), .o_fault(o_fault),
    .o_cmp_cnt(o_cmp_cnt), .o_mis_cnt(o_mis_cnt), .o_fault_ch(o_fault_ch), .o_fault_addr(o_fault_addr),
    .o_fault_ref(o_fault_ref), .o_fault_uut(o_fault_uut));
  typedef struct {logic [NC-1:0] en; logic [NC*AW-1:0] addr;} req_t;
  typedef struct {int st; bit eq; int cmp; int mis; int ch; logic [AW-1:0] fa; logic [DW-1:0] fr, fu;} exp_t;
  req_t hist[$];
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  int m_st, m_cmp, m_mis, m_ch;
  bit m_eq;
  logic [AW-1:0] m_fa;
  logic [DW-1:0] m_fr, m_fu;
  logic [AW-1:0] save_a;
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic wipe();
    req_t z;
    z.en = '0;
    z.addr = '0;
    m_st = 0; m_eq = 1; m_cmp = 0; m_mis = 0; m_ch = 0; m_fa = '0; m_fr = '0; m_fu = '0;
    hist.delete();
    repeat (LAT) hist.push_back(z);
  endtask
  // Request issued LAT cycles ago is compared against this cycle's data.
  task automatic model();
    req_t cur, d;
    bit anyq, anym;
    int first;
    exp_t e;
    if (!rst_n) wipe();
    else begin
      cur.en = en;
      cur.addr = addr;
      hist.push_back(cur);
      d = hist.pop_front();
      anyq = 0; anym = 0; first = -1;
      for (int k = 0; k < NC; k++)
        if (d.en[k] && m_st != 0) begin
          anyq = 1;
          if (dref[k*DW +: DW] != duut[k*DW +: DW]) begin
            anym = 1;
            if (first < 0) first = k;
          end
        end
      if (clr) wipe();
      else begin
        m_eq = !anym;
        if (anyq && m_cmp < CMAX) m_cmp++;
        if (anym && m_mis < CMAX) m_mis++;
        if (m_st == 1 && anym) begin
          m_st = 2; m_ch = first;
          m_fa = d.addr[first*AW +: AW];
          m_fr = dref[first*DW +: DW];
          m_fu = duut[first*DW +: DW];
        end else if (m_st == 0 && arm) m_st = 1;
      end
    end
    e.st = m_st; e.eq = m_eq; e.cmp = m_cmp; e.mis = m_mis; e.ch = m_ch; e.fa = m_fa; e.fr = m_fr; e.fu = m_fu;
    sb.push_back(e);
  endtask
  task automatic tick();
    model();
    @(negedge clk);
  endtask
  task automatic quiet();
    arm = 0; clr = 0; en = '0;
    addr = NC*AW'($urandom);
    dref = {$urandom, $urandom};
    duut = dref;
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("state", o_state, mon_e.st);
      chk("equal", o_equal, mon_e.eq);
      chk("fault", o_fault, mon_e.st == 2);
      chk("cmp_cnt", o_cmp_cnt, mon_e.cmp);
      chk("mis_cnt", o_mis_cnt, mon_e.mis);
      chk("fault_ch", o_fault_ch, mon_e.ch);
      chk("fault_addr", o_fault_addr, mon_e.fa);
      chk("fault_ref", o_fault_ref, mon_e.fr);
      chk("fault_uut", o_fault_uut, mon_e.fu);
    end
  end
  initial begin
    rst_n = 0;
    quiet();
    @(negedge clk);
    tick();
    rst_n = 1;
    chk("rst_state", o_state, 0);
    chk("rst_equal", o_equal, 1);
    chk("rst_cmp", o_cmp_cnt, 0);
    quiet(); arm = 1; tick();
    quiet(); en = 2'b01; addr[0 +: AW] = 10'h005; tick();
    quiet(); dref[0 +: DW] = 32'hA5A5A5A5; duut[0 +: DW] = 32'hA5A5A5A5; tick();
    chk("match_equal", o_equal, 1);
    chk("match_cmp", o_cmp_cnt, 1);
    chk("match_state", o_state, 1);
    quiet(); en = 2'b10; addr[AW +: AW] = 10'h3FF; tick();
    quiet(); dref[DW +: DW] = 32'h1; duut[DW +: DW] = 32'h3; tick();
    chk("mis_state", o_state, 2);
    chk("mis_ch", o_fault_ch, 1);
    chk("mis_addr", o_fault_addr, 10'h3FF);
    chk("mis_ref", o_fault_ref, 1);
    chk("mis_uut", o_fault_uut, 3);
    chk("mis_cnt1", o_mis_cnt, 1);
    quiet(); clr = 1; tick();
    quiet(); arm = 1; tick();
    quiet(); en = 2'b11; save_a = addr[0 +: AW]; tick();
    quiet(); duut = ~dref; tick();
    chk("both_ch", o_fault_ch, 0);
    chk("both_addr", o_fault_addr, save_a);
    quiet(); en = 2'b10; tick();
    quiet(); duut[DW +: DW] = ~dref[DW +: DW]; tick();
    chk("later_ch", o_fault_ch, 0);
    chk("later_addr", o_fault_addr, save_a);
    chk("later_mis", o_mis_cnt, 2);
    quiet(); duut = ~dref; tick();
    chk("noen_mis", o_mis_cnt, 2);
    chk("noen_equal", o_equal, 1);
    quiet(); clr = 1; tick();
    quiet(); en = 2'b11; tick();
    quiet(); en = 2'b11; duut = ~dref; tick();
    chk("idle_state", o_state, 0);
    chk("idle_cmp", o_cmp_cnt, 0);
    chk("idle_equal", o_equal, 1);
    quiet(); arm = 1; tick();
    repeat (21) begin
      quiet(); en = 2'b11; duut = ~dref; tick();
    end
    chk("sat_mis", o_mis_cnt, 15);
    chk("sat_cmp", o_cmp_cnt, 15);
    quiet(); clr = 1; arm = 1; tick();
    chk("clrarm_state", o_state, 0);
    chk("clrarm_cmp", o_cmp_cnt, 0);
    chk("clrarm_mis", o_mis_cnt, 0);
    quiet(); arm = 1; tick();
    quiet(); en = 2'b11; tick();
    quiet(); en = 2'b11; tick();
    quiet(); rst_n = 0; en = 2'b11; tick();
    rst_n = 1;
    chk("rstarm_state", o_state, 0);
    chk("rstarm_cmp", o_cmp_cnt, 0);
    chk("rstarm_equal", o_equal, 1);
    repeat (3000) begin
      quiet();
      rst_n = ($urandom_range(99) != 0);
      clr = ($urandom_range(29) == 0);
      arm = ($urandom_range(7) == 0);
      en = NC'($urandom);
      for (int k = 0; k < NC; k++)
        if ($urandom_range(4) == 0) duut[k*DW + int'($urandom_range(DW-1))] ^= 1'b1;
      tick();
    end
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
